// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// Holds the FSM state type, bus widths and the byte-lane merge.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [WORD_W-1:0] m;
    m = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one byte-enabled write port and one synchronous read port.
// Contents are deliberately never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, wstrb_i);
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store target with programmable wait states.
// One transaction in flight: accept, wait LATENCY cycles, respond.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              valid_q;
  logic              err_q;
  logic              rd_ok_q;

  logic              accept;
  logic              access;
  logic              cur_we;
  logic              cur_err;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [STRB_W-1:0] cur_wstrb;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // With zero latency the access uses the live request, not the latch
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_wstrb = wstrb_q;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
    end
  end

  assign access = (state_q == WAIT && cnt_q == 4'd1)
               || (accept && LATENCY == 0);

  assign cur_err = (cur_addr[1:0] != 2'b00)
                || (cur_addr[WORD_W-1:2] >= 30'(DEPTH));

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (access && cur_we && !cur_err),
    .re_i    (access && !cur_we && !cur_err),
    .addr_i  (cur_addr[AW+1:2]),
    .wdata_i (cur_wdata),
    .wstrb_i (cur_wstrb),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            cnt_q   <= LAT;
            state_q <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (access) begin
        valid_q <= 1'b1;
        err_q   <= cur_err;
        rd_ok_q <= !cur_we && !cur_err;
      end
    end
  end

  // Read data stays in the array's output register until the next read
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? arr_rdata : '0;

endmodule
